// File: rtl/branch_predictor_unit.sv
// Combined 2-bit-counter direction predictor (bimodal or gshare) and direct-mapped tagged BTB.
// One registered lookup and one resolved-branch update per cycle; lookups read pre-update state.
module branch_predictor_unit #(
  parameter int         PC_W     = 12,
  parameter int         IDX_W    = 6,
  parameter int         BTB_W    = 5,
  parameter int         GHR_W    = 0,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pred_valid,
  input  logic [PC_W-1:0] pred_pc,
  output logic            pred_out_valid,
  output logic            pred_taken,
  output logic            pred_hit,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            flush
);

  localparam int NCNT  = 1 << IDX_W;
  localparam int NBTB  = 1 << BTB_W;
  localparam int TAG_W = PC_W - BTB_W - 2;

  function automatic logic [1:0] sat_cnt(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? 2'b11 : c + 2'd1;
    else       return (c == 2'b00) ? 2'b00 : c - 2'd1;
  endfunction

  logic             upd_en;
  logic             btb_wr;
  logic [IDX_W-1:0] hist;
  logic [IDX_W-1:0] pred_cidx, upd_cidx;
  logic [BTB_W-1:0] pred_bidx, upd_bidx;
  logic [TAG_W-1:0] pred_tag, upd_tag;
  logic             unused_pc_lsbs;

  // A flush in the same cycle drops the update entirely.
  assign upd_en = upd_valid & ~flush;
  assign btb_wr = upd_en & upd_taken;

  generate
    if (GHR_W > 0) begin : g_gshare
      logic [GHR_W-1:0] ghr_q, ghr_d;

      always_comb begin
        ghr_d = ghr_q;
        if (flush)          ghr_d = '0;
        else if (upd_valid) ghr_d = GHR_W'({ghr_q, upd_taken});
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ghr_q <= '0;
        else        ghr_q <= ghr_d;
      end

      // Both indices use the current (pre-shift) history.
      assign hist = IDX_W'(ghr_q);
    end else begin : g_bimodal
      assign hist = '0;
    end
  endgenerate

  assign pred_cidx      = pred_pc[IDX_W+1:2] ^ hist;
  assign upd_cidx       = upd_pc[IDX_W+1:2] ^ hist;
  assign pred_bidx      = pred_pc[BTB_W+1:2];
  assign upd_bidx       = upd_pc[BTB_W+1:2];
  assign pred_tag       = pred_pc[PC_W-1:BTB_W+2];
  assign upd_tag        = upd_pc[PC_W-1:BTB_W+2];
  assign unused_pc_lsbs = ^{pred_pc[1:0], upd_pc[1:0]};

  logic [1:0]      cnt_q [NCNT];
  logic [1:0]      cnt_wr_d;
  logic [NBTB-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [NBTB];
  logic [PC_W-1:0]  tgt_q [NBTB];

  assign cnt_wr_d = sat_cnt(cnt_q[upd_cidx], upd_taken);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCNT; i++) cnt_q[i] <= CNT_INIT;
    end else if (upd_en) begin
      cnt_q[upd_cidx] <= cnt_wr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      valid_q <= '0;
    else if (flush)  valid_q <= '0;
    else if (btb_wr) valid_q[upd_bidx] <= 1'b1;
  end

  // Tag and target are qualified by the valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (btb_wr) begin
      tag_q[upd_bidx] <= upd_tag;
      tgt_q[upd_bidx] <= upd_target;
    end
  end

  logic            lu_hit;
  logic            pred_out_valid_d, pred_hit_d, pred_taken_d;
  logic [PC_W-1:0] pred_target_d;
  logic            pred_out_valid_q, pred_hit_q, pred_taken_q;
  logic [PC_W-1:0] pred_target_q;

  always_comb begin
    lu_hit           = valid_q[pred_bidx] && (tag_q[pred_bidx] == pred_tag);
    pred_out_valid_d = pred_valid;
    pred_hit_d       = pred_valid & lu_hit;
    pred_taken_d     = pred_hit_d & cnt_q[pred_cidx][1];
    pred_target_d    = pred_hit_d ? tgt_q[pred_bidx] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_out_valid_q <= 1'b0;
      pred_hit_q       <= 1'b0;
      pred_taken_q     <= 1'b0;
      pred_target_q    <= '0;
    end else begin
      pred_out_valid_q <= pred_out_valid_d;
      pred_hit_q       <= pred_hit_d;
      pred_taken_q     <= pred_taken_d;
      pred_target_q    <= pred_target_d;
    end
  end

  assign pred_out_valid = pred_out_valid_q;
  assign pred_hit       = pred_hit_q;
  assign pred_taken     = pred_taken_q;
  assign pred_target    = pred_target_q;

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Bench for branch_predictor_unit: a bimodal and a gshare (GHR_W=4) instance share one
// stimulus stream and are compared every cycle against an array-based reference model.
module tb_branch_predictor_unit;
  localparam int PC_W = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, pred_valid, upd_valid, upd_taken, flush;
  logic [PC_W-1:0] pred_pc, upd_pc, upd_target;
  logic            b_ov, b_tk, b_hit, g_ov, g_tk, g_hit;
  logic [PC_W-1:0] b_tgt, g_tgt;

  branch_predictor_unit #(.PC_W(12), .IDX_W(6), .BTB_W(5), .GHR_W(0), .CNT_INIT(2'b01)) u_bi (
    .clk(clk), .rst_n(rst_n), .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_out_valid(b_ov), .pred_taken(b_tk), .pred_hit(b_hit), .pred_target(b_tgt),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .flush(flush));

  branch_predictor_unit #(.PC_W(12), .IDX_W(6), .BTB_W(5), .GHR_W(4), .CNT_INIT(2'b01)) u_gs (
    .clk(clk), .rst_n(rst_n), .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_out_valid(g_ov), .pred_taken(g_tk), .pred_hit(g_hit), .pred_target(g_tgt),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .flush(flush));

  // Reference model: index 0 = bimodal, index 1 = gshare with 4 history bits.
  int m_cnt [2][64];
  bit m_val [2][32];
  int m_tag [2][32];
  int m_tgt [2][32];
  int m_ghr [2];
  int e_ov [2], e_tk [2], e_hit [2], e_tgt [2];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pins both the DUT and the model to a hand-derived value.
  task automatic lit(input string name, input logic [31:0] dutv, input int modelv, input int want);
    chk(name, dutv, want);
    chk({name, "_model"}, modelv, want);
  endtask

  function automatic int cidx(input int m, input int pc);
    return ((pc >> 2) & 63) ^ ((m == 1) ? m_ghr[1] : 0);
  endfunction

  task automatic m_reset_one(input int m);
    for (int i = 0; i < 64; i++) m_cnt[m][i] = 1;
    for (int i = 0; i < 32; i++) m_val[m][i] = 1'b0;
    m_ghr[m] = 0;
    e_ov[m] = 0; e_tk[m] = 0; e_hit[m] = 0; e_tgt[m] = 0;
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int ppc, upc, b, c;
    bit h;
    ppc = int'(pred_pc);
    upc = int'(upd_pc);
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        m_reset_one(m);
      end else begin
        if (pred_valid) begin
          b = (ppc >> 2) & 31;
          h = m_val[m][b] && (m_tag[m][b] == (ppc >> 7));
          e_ov[m]  = 1;
          e_hit[m] = h;
          e_tk[m]  = (h && m_cnt[m][cidx(m, ppc)] >= 2) ? 1 : 0;
          e_tgt[m] = h ? m_tgt[m][b] : 0;
        end else begin
          e_ov[m] = 0; e_hit[m] = 0; e_tk[m] = 0; e_tgt[m] = 0;
        end
        if (flush) begin
          for (int i = 0; i < 32; i++) m_val[m][i] = 1'b0;
          m_ghr[m] = 0;
        end else if (upd_valid) begin
          c = cidx(m, upc);
          if (upd_taken) m_cnt[m][c] = (m_cnt[m][c] < 3) ? m_cnt[m][c] + 1 : 3;
          else           m_cnt[m][c] = (m_cnt[m][c] > 0) ? m_cnt[m][c] - 1 : 0;
          if (upd_taken) begin
            b = (upc >> 2) & 31;
            m_val[m][b] = 1'b1;
            m_tag[m][b] = upc >> 7;
            m_tgt[m][b] = int'(upd_target);
          end
          if (m == 1) m_ghr[1] = ((m_ghr[1] << 1) | int'(upd_taken)) & 15;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("bi_out_valid", b_ov,  e_ov[0]);
    chk("bi_hit",       b_hit, e_hit[0]);
    chk("bi_taken",     b_tk,  e_tk[0]);
    chk("bi_target",    b_tgt, e_tgt[0]);
    chk("gs_out_valid", g_ov,  e_ov[1]);
    chk("gs_hit",       g_hit, e_hit[1]);
    chk("gs_taken",     g_tk,  e_tk[1]);
    chk("gs_target",    g_tgt, e_tgt[1]);
  endtask

  // Called just after a falling edge: drive, step the model, then check at the next falling edge.
  task automatic cycle(input bit pv, input int ppc, input bit uv, input int upc,
                       input bit ut, input int utg, input bit fl);
    pred_valid = pv;  pred_pc = ppc[PC_W-1:0];
    upd_valid  = uv;  upd_pc  = upc[PC_W-1:0];
    upd_taken  = ut;  upd_target = utg[PC_W-1:0];
    flush      = fl;
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic lookup(input int pc);
    cycle(1'b1, pc, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic upd(input int pc, input bit t, input int tg);
    cycle(1'b0, 0, 1'b1, pc, t, tg, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
  endtask

  function automatic int rand_pc();
    if ($urandom_range(0, 1) == 0) return int'($urandom & 32'hFFC);
    return (int'($urandom_range(0, 7)) << 2) | (int'($urandom_range(0, 1)) << 7);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    pred_valid = 1'b0; pred_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; flush = 1'b0;
    m_reset_one(0); m_reset_one(1);
    idle(); idle();
    lit("rst_ov",  b_ov,  e_ov[0],  0);
    lit("rst_hit", b_hit, e_hit[0], 0);
    lit("rst_tgt", b_tgt, e_tgt[0], 0);
    rst_n = 1'b1;

    for (int i = 0; i < 30; i++)
      cycle($urandom_range(0, 1) == 1, rand_pc(), 1'b1, rand_pc(), $urandom_range(0, 1) == 1,
            int'($urandom & 32'hFFC), 1'b0);
    lookup('h040);
    chk("pre_rst_ov", b_ov, 1);

    // Asynchronous reset must clear outputs without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ov",  b_ov,  0);
    chk("async_rst_tgt", g_tgt, 0);
    chk("async_rst_hit", g_hit, 0);
    m_reset_one(0); m_reset_one(1);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    lookup('h040);
    lit("post_rst_ov",  b_ov,  e_ov[0],  1);
    lit("post_rst_hit", b_hit, e_hit[0], 0);
    lit("post_rst_tk",  b_tk,  e_tk[0],  0);
    lit("post_rst_tgt", b_tgt, e_tgt[0], 0);

    // Training: 01 -> 10 -> 11, then back down to 01.
    upd('h040, 1'b1, 'h100); upd('h040, 1'b1, 'h100);
    lookup('h040);
    lit("train_hit", b_hit, e_hit[0], 1);
    lit("train_tk",  b_tk,  e_tk[0],  1);
    lit("train_tgt", b_tgt, e_tgt[0], 'h100);
    upd('h040, 1'b0, 0); upd('h040, 1'b0, 0);
    lookup('h040);
    lit("untrain_tk",  b_tk,  e_tk[0],  0);
    lit("untrain_hit", b_hit, e_hit[0], 1);

    // Saturation at both ends.
    for (int i = 0; i < 5; i++) upd('h080, 1'b1, 'h180);
    upd('h080, 1'b0, 0); upd('h080, 1'b0, 0);
    lookup('h080);
    lit("sat_hi_tk",  b_tk,  e_tk[0],  0);
    lit("sat_hi_tgt", b_tgt, e_tgt[0], 'h180);
    upd('h080, 1'b0, 0); upd('h080, 1'b0, 0);
    upd('h080, 1'b1, 'h180);
    lookup('h080);
    lit("sat_lo_tk", b_tk, e_tk[0], 0);
    upd('h080, 1'b1, 'h180);
    lookup('h080);
    lit("sat_lo_tk2", b_tk, e_tk[0], 1);

    // Aliasing: same BTB index, different tag.
    upd('h004, 1'b1, 'h200); upd('h084, 1'b1, 'h300);
    lookup('h004);
    lit("alias_old_hit", b_hit, e_hit[0], 0);
    lit("alias_old_tgt", b_tgt, e_tgt[0], 0);
    lookup('h084);
    lit("alias_new_hit", b_hit, e_hit[0], 1);
    lit("alias_new_tgt", b_tgt, e_tgt[0], 'h300);

    // Read-before-write in one cycle, visible the next.
    cycle(1'b1, 'h010, 1'b1, 'h010, 1'b1, 'h050, 1'b0);
    lit("rbw_hit", b_hit, e_hit[0], 0);
    lookup('h010);
    lit("rbw_next_hit", b_hit, e_hit[0], 1);
    lit("rbw_next_tgt", b_tgt, e_tgt[0], 'h050);

    // Flush: same-cycle lookup sees old state, update is dropped, counters kept.
    cycle(1'b1, 'h010, 1'b1, 'h020, 1'b1, 'h060, 1'b1);
    lit("flush_same_hit", b_hit, e_hit[0], 1);
    lookup('h010);
    lit("flush_after_hit", b_hit, e_hit[0], 0);
    lit("flush_after_tk",  b_tk,  e_tk[0],  0);
    lookup('h020);
    lit("flush_drop_hit", b_hit, e_hit[0], 0);
    upd('h010, 1'b1, 'h050); upd('h010, 1'b0, 0);
    lookup('h010);
    lit("flush_keep_tk", b_tk, e_tk[0], 1);
    upd('h020, 1'b1, 'h060); upd('h020, 1'b0, 0);
    lookup('h020);
    lit("flush_drop_cnt_tk",  b_tk,  e_tk[0],  0);
    lit("flush_drop_cnt_tgt", b_tgt, e_tgt[0], 'h060);

    // Gshare: T,T,N,T leaves history 1101; pc 0x000 then reads counter 0xD.
    do_reset();
    upd('h000, 1'b1, 'h2A0); upd('h000, 1'b1, 'h2A0);
    upd('h000, 1'b0, 0);     upd('h000, 1'b1, 'h2A0);
    chk("gs_ghr_model", m_ghr[1], 'hD);
    lookup('h000);
    lit("gs_hit", g_hit, e_hit[1], 1);
    lit("gs_tk",  g_tk,  e_tk[1],  0);
    lit("gs_tgt", g_tgt, e_tgt[1], 'h2A0);
    lit("gs_bi_tk", b_tk, e_tk[0], 1);

    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 3) != 0, rand_pc(), $urandom_range(0, 3) != 0, rand_pc(),
            $urandom_range(0, 9) < 6, int'($urandom & 32'hFFC), $urandom_range(0, 49) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
